// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage RV32 pipeline.
// It combines four hazard sources into per-stage write enables and flushes:
// data-memory wait, a multi-cycle divide in EX, a taken branch, and load-use.
// It also owns the divider occupancy FSM and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_reg_wen,
  input  logic             i_ex_div_start,
  input  logic             i_ex_branch_taken,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_pc_wen,
  output logic             o_if_id_wen,
  output logic             o_id_ex_wen,
  output logic             o_ex_mem_wen,
  output logic             o_mem_wb_wen,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_flush,
  output logic             o_div_busy,
  output logic [CNT_W-1:0] o_stall_cycles
);

  typedef enum logic {ST_RUN, ST_DIV_WAIT} state_t;

  // EX stays occupied for DIV_LATENCY cycles in total.
  // The first of those cycles is spent in RUN, so DIV_WAIT is loaded with one less.
  localparam logic [5:0] DIV_LOAD = 6'(DIV_LATENCY - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_div_cnt;
  logic [5:0]       w_div_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_load_use;
  logic             w_mem_stall;
  logic             w_div_freeze;

  assign w_mem_stall = i_dmem_req & ~i_dmem_ready;
  assign w_load_use  = i_ex_mem_read & i_ex_reg_wen & (i_ex_rd != 5'd0) &
                       ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));
  // The divider freezes the front of the pipe on its start cycle and on every
  // DIV_WAIT cycle except the last one.
  // That last cycle releases the divider and behaves like a normal cycle.
  assign w_div_freeze = ((r_state == ST_DIV_WAIT) && (r_div_cnt > 6'd1)) ||
                        ((r_state == ST_RUN) && i_ex_div_start);

  // Divider FSM state and occupancy counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_div_cnt <= 6'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_cnt_nxt;
    end
  end

  // Next-state logic and prioritised stage enables/flushes
  always_comb begin
    w_state_nxt    = r_state;
    w_div_cnt_nxt  = r_div_cnt;
    o_pc_wen       = 1'b1;
    o_if_id_wen    = 1'b1;
    o_id_ex_wen    = 1'b1;
    o_ex_mem_wen   = 1'b1;
    o_mem_wb_wen   = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_flush = 1'b0;
    o_div_busy     = (r_state != ST_RUN);
    if (rst) begin
      o_pc_wen       = 1'b0;
      o_if_id_wen    = 1'b0;
      o_id_ex_wen    = 1'b0;
      o_ex_mem_wen   = 1'b0;
      o_mem_wb_wen   = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_flush  = 1'b1;
      o_ex_mem_flush = 1'b1;
      o_div_busy     = 1'b0;
    end else if (w_mem_stall) begin
      // Freeze the whole pipe; the divider does not advance either
      o_pc_wen     = 1'b0;
      o_if_id_wen  = 1'b0;
      o_id_ex_wen  = 1'b0;
      o_ex_mem_wen = 1'b0;
      o_mem_wb_wen = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_ex_div_start) begin
            w_state_nxt   = ST_DIV_WAIT;
            w_div_cnt_nxt = DIV_LOAD;
          end
        end
        ST_DIV_WAIT: begin
          if (r_div_cnt > 6'd1) begin
            w_div_cnt_nxt = r_div_cnt - 6'd1;
          end else begin
            w_state_nxt   = ST_RUN;
            w_div_cnt_nxt = 6'd0;
          end
        end
        default: begin
          w_state_nxt   = ST_RUN;
          w_div_cnt_nxt = 6'd0;
        end
      endcase
      if (w_div_freeze) begin
        // Hold IF/ID/EX and push bubbles into MEM while the divide runs
        o_pc_wen       = 1'b0;
        o_if_id_wen    = 1'b0;
        o_id_ex_wen    = 1'b0;
        o_ex_mem_flush = 1'b1;
      end else if (i_ex_branch_taken) begin
        // Any load-use is on the wrong path, so squashing it is enough
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        o_pc_wen      = 1'b0;
        o_if_id_wen   = 1'b0;
        o_id_ex_flush = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (!o_pc_wen && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Two instances share the same inputs:
//   - u_dut uses a 32-bit stall counter;
//   - u_sat uses a 4-bit stall counter to exercise saturation.
// Both use DIV_LATENCY=4.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_mem_read, ex_reg_wen, ex_div_start, ex_branch_taken;
  logic        dmem_req, dmem_ready;
  logic        pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, div_busy;
  logic [31:0] stall_cycles;
  logic        s_pc_wen, s_if_id_wen, s_id_ex_wen, s_ex_mem_wen, s_mem_wb_wen;
  logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_div_busy;
  logic [3:0]  s_stall_cycles;

  int total = 0;
  int bad   = 0;
  int exp_cnt;

  // Control-vector encodings: {pc, if_id, id_ex, ex_mem, mem_wb wen, if_id, id_ex, ex_mem flush}
  localparam logic [7:0] C_IDLE   = 8'b11111_000;
  localparam logic [7:0] C_RESET  = 8'b00000_111;
  localparam logic [7:0] C_LDUSE  = 8'b00111_010;
  localparam logic [7:0] C_BRANCH = 8'b11111_110;
  localparam logic [7:0] C_DIV    = 8'b00011_001;
  localparam logic [7:0] C_MEM    = 8'b00000_000;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DIV_LATENCY(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_ex_rd(ex_rd),
    .i_ex_mem_read(ex_mem_read), .i_ex_reg_wen(ex_reg_wen),
    .i_ex_div_start(ex_div_start), .i_ex_branch_taken(ex_branch_taken),
    .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
    .o_pc_wen(pc_wen), .o_if_id_wen(if_id_wen), .o_id_ex_wen(id_ex_wen),
    .o_ex_mem_wen(ex_mem_wen), .o_mem_wb_wen(mem_wb_wen),
    .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
    .o_ex_mem_flush(ex_mem_flush), .o_div_busy(div_busy),
    .o_stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.DIV_LATENCY(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_ex_rd(ex_rd),
    .i_ex_mem_read(ex_mem_read), .i_ex_reg_wen(ex_reg_wen),
    .i_ex_div_start(ex_div_start), .i_ex_branch_taken(ex_branch_taken),
    .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
    .o_pc_wen(s_pc_wen), .o_if_id_wen(s_if_id_wen), .o_id_ex_wen(s_id_ex_wen),
    .o_ex_mem_wen(s_ex_mem_wen), .o_mem_wb_wen(s_mem_wb_wen),
    .o_if_id_flush(s_if_id_flush), .o_id_ex_flush(s_id_ex_flush),
    .o_ex_mem_flush(s_ex_mem_flush), .o_div_busy(s_div_busy),
    .o_stall_cycles(s_stall_cycles)
  );

  // The stimulus must never raise a divide start and a taken branch together
  always @(posedge clk) begin
    assert (!(ex_div_start && ex_branch_taken))
      else $error("FAIL input_exclusive div_start=%0b branch=%0b", ex_div_start, ex_branch_taken);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
              if_id_flush, id_ex_flush, ex_mem_flush}, {24'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; ex_reg_wen = 1'b0; ex_div_start = 1'b0;
    ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    // Reset state
    chk_ctl("reset_ctl", C_RESET);
    chk("reset_busy", {31'd0, div_busy}, 32'd0);
    chk("reset_cnt", stall_cycles, 32'd0);
    rst = 1'b0;
    #1;
    chk_ctl("idle_ctl", C_IDLE);
    step();
    exp_cnt = 0;

    // Load-use: lw x5 in EX while ID reads x5 through rs2
    ex_mem_read = 1'b1; ex_reg_wen = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
    #1;
    chk_ctl("load_use_ctl", C_LDUSE);
    step();
    exp_cnt = exp_cnt + 1;
    ex_mem_read = 1'b0; ex_reg_wen = 1'b0;
    #1;
    chk_ctl("load_use_after", C_IDLE);
    chk("load_use_cnt", stall_cycles, exp_cnt);

    // Loading into x0 is never a hazard
    ex_mem_read = 1'b1; ex_reg_wen = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd9;
    #1;
    chk_ctl("x0_no_stall", C_IDLE);
    // Without a load, a matching rd is forwarded, so there is no stall
    ex_mem_read = 1'b0; ex_reg_wen = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
    #1;
    chk_ctl("nonload_no_stall", C_IDLE);
    step();

    // A taken branch overrides load-use
    ex_mem_read = 1'b1; ex_reg_wen = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd1; id_rs2 = 5'd5;
    ex_branch_taken = 1'b1;
    #1;
    chk_ctl("branch_over_lu", C_BRANCH);
    step();
    chk("branch_cnt", stall_cycles, exp_cnt);
    idle_inputs();

    // Divide, DIV_LATENCY=4: three frozen cycles, then the release cycle
    ex_div_start = 1'b1;
    #1;
    chk_ctl("div_start_ctl", C_DIV);
    chk("div_start_busy", {31'd0, div_busy}, 32'd0);
    step();
    ex_div_start = 1'b0;
    chk_ctl("div_wait3_ctl", C_DIV);
    chk("div_wait3_busy", {31'd0, div_busy}, 32'd1);
    step();
    chk_ctl("div_wait2_ctl", C_DIV);
    step();
    chk_ctl("div_release_ctl", C_IDLE);
    chk("div_release_busy", {31'd0, div_busy}, 32'd1);
    step();
    exp_cnt = exp_cnt + 3;
    chk("div_done_busy", {31'd0, div_busy}, 32'd0);
    chk("div_cnt", stall_cycles, exp_cnt);

    // Memory wait inside a divide stretches the freeze by exactly two cycles
    ex_div_start = 1'b1;
    #1;
    chk_ctl("mdiv_start_ctl", C_DIV);
    step();
    ex_div_start = 1'b0; dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    chk_ctl("mdiv_mem1_ctl", C_MEM);
    step();
    chk_ctl("mdiv_mem2_ctl", C_MEM);
    chk("mdiv_mem2_busy", {31'd0, div_busy}, 32'd1);
    step();
    dmem_ready = 1'b1;
    #1;
    chk_ctl("mdiv_wait3_ctl", C_DIV);
    step();
    chk_ctl("mdiv_wait2_ctl", C_DIV);
    step();
    chk_ctl("mdiv_release_ctl", C_IDLE);
    step();
    exp_cnt = exp_cnt + 5;
    chk("mdiv_done_busy", {31'd0, div_busy}, 32'd0);
    chk("mdiv_cnt", stall_cycles, exp_cnt);
    dmem_req = 1'b0;

    // Reset while the divider counter is at 2
    ex_div_start = 1'b1;
    step();
    ex_div_start = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk_ctl("rst_mid_ctl", C_RESET);
    chk("rst_mid_busy", {31'd0, div_busy}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk_ctl("post_rst_ctl", C_IDLE);
    chk("post_rst_busy", {31'd0, div_busy}, 32'd0);
    chk("post_rst_cnt", stall_cycles, 32'd0);
    chk("post_rst_sat_cnt", {28'd0, s_stall_cycles}, 32'd0);

    // A memory stall outranks a branch, and the 4-bit counter must saturate
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    #1;
    chk_ctl("mem_over_branch", C_MEM);
    for (int i = 0; i < 14; i++) step();
    chk("sat_14", {28'd0, s_stall_cycles}, 32'd14);
    step();
    chk("sat_15", {28'd0, s_stall_cycles}, 32'hF);
    for (int i = 0; i < 5; i++) step();
    chk("sat_20", {28'd0, s_stall_cycles}, 32'hF);
    chk("wide_20", stall_cycles, 32'd20);
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
